// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage in front of main_decoder. Owns the PC and issues word reads to
// instruction memory, with at most one read outstanding. Returned words go into
// a 2-entry FIFO, and the FIFO head is presented to decode as {pc, instr, op}.
// A branch/jump redirect flushes the buffered words and any in-flight word.
//
// Optional feature (compile-time macro):
//   ILLEGAL_OP_CHECK_EN - when defined, instr_illegal flags a valid head whose
//                         opcode is outside {lw, sw, R-type, beq, addi}.
//                         When undefined, instr_illegal is tied 0.
//
// Parameters:
//   XLEN     - PC / address / instruction width
//   RESET_PC - PC loaded on reset
//   PC_STEP  - byte increment per sequential fetch
//
// Ports:
//   clk, reset       - rising-edge clock, asynchronous active-high reset
//   imem_req_*       - request channel (valid/ready, word-aligned address)
//   imem_rsp_*       - in-order response channel (valid only, no backpressure)
//   redirect_*       - taken branch/jump target from execute
//   instr_valid/ready- handshake with decode on the FIFO head
//   instr_data/pc/op - FIFO head word, its PC, and its opcode field
//   instr_illegal    - head opcode unsupported (feature-dependent)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      instr_op,
    output logic            instr_illegal
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] fetch_pc_q;   // address of the outstanding request
    logic            drop_q;       // outstanding response belongs to a flushed path
    logic            req_valid_q;

    logic [XLEN-1:0] fifo_data_q [2];
    logic [XLEN-1:0] fifo_pc_q   [2];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      count_q;

    logic            accept;
    logic            push;
    logic            pop;
    logic [1:0]      count_d;

    // A redirect withdraws the pending request and hides the head in the same
    // cycle, so neither an accept nor a pop can slip through on the old path.
    assign imem_req_valid = req_valid_q && !redirect_valid;
    assign imem_req_addr  = pc_q & ALIGN_MASK;
    assign instr_valid    = (count_q != 2'd0) && !redirect_valid;
    assign instr_data     = fifo_data_q[rd_ptr_q];
    assign instr_pc       = fifo_pc_q[rd_ptr_q];
    assign instr_op       = instr_data[6:0];

    always_comb begin
        accept  = imem_req_valid && imem_req_ready;
        push    = (state_q == S_WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;
        pop     = instr_valid && instr_ready;
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= '0;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ALIGN_MASK;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            if (state_q == S_WAIT && !imem_rsp_valid) begin
                // Old-path response still owed by memory: swallow it when it
                // arrives, then fetch from the new PC.
                drop_q      <= 1'b1;
                req_valid_q <= 1'b0;
            end else begin
                // Idle, or the owed response arrives now and is discarded.
                state_q     <= S_IDLE;
                drop_q      <= 1'b0;
                req_valid_q <= 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_WAIT;
                        pc_q        <= pc_q + STEP;
                        fetch_pc_q  <= imem_req_addr;
                        req_valid_q <= 1'b0;
                    end else begin
                        // Only issue when a FIFO slot is free; that reservation
                        // is what keeps the later push from overflowing.
                        req_valid_q <= (count_d != 2'd2);
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_q     <= S_IDLE;
                        drop_q      <= 1'b0;
                        req_valid_q <= (count_d != 2'd2);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase

            if (push) begin
                fifo_data_q[wr_ptr_q] <= imem_rsp_data;
                fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

`ifdef ILLEGAL_OP_CHECK_EN
    logic op_legal;

    always_comb begin
        op_legal = 1'b0;
        case (instr_op)
            7'b0000011,          // lw
            7'b0100011,          // sw
            7'b0110011,          // R-type
            7'b1100011,          // beq
            7'b0010011: op_legal = 1'b1;  // addi
            default:    op_legal = 1'b0;
        endcase
    end

    // Flag only; fetch keeps going and decode/trap decides what to do.
    assign instr_illegal = instr_valid && !op_legal;
`else
    assign instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
    logic [6:0]  instr_op;
    logic        instr_illegal;

    // second instance for the top-of-address-space wrap case
    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_instr_valid, w_instr_ready;
    logic [31:0] w_instr_data, w_instr_pc;
    logic [6:0]  w_instr_op;
    logic        w_instr_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .instr_op(instr_op),
        .instr_illegal(instr_illegal)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .instr_data(w_instr_data), .instr_pc(w_instr_pc), .instr_op(w_instr_op),
        .instr_illegal(w_instr_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Memory image: word derived from its address, with two fixed words for
    // the opcode-legality case.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h0000_0037;
        if (a == 32'h0000_0204) return 32'h0000_0013;
        return {~a[31:7], a[6:2], 2'b11};
    endfunction

    function automatic logic exp_illegal(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
`ifdef ILLEGAL_OP_CHECK_EN
        return !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011});
`else
        return (op == 7'h7F) && 1'b0;
`endif
    endfunction

    // ---------------- memory model (single outstanding, variable latency)
    logic        rnd_ready, rnd_lat;
    int          fix_lat;
    logic        mem_busy;
    int          mem_left;
    logic [31:0] mem_addr;
    logic [31:0] acc_q[$];

    initial begin
        logic        acc;
        logic [31:0] a;
        int          lat;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_busy = 1'b0;
        mem_left = 0;
        mem_addr = '0;
        lat = 1;
        forever begin
            @(negedge clk);
            acc = imem_req_valid && imem_req_ready;
            a   = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (reset) begin
                mem_busy = 1'b0;
            end else begin
                if (acc) begin
                    chk("one_outstanding", {31'b0, mem_busy}, 32'd0);
                    mem_busy = 1'b1;
                    mem_left = lat;
                    mem_addr = a;
                    acc_q.push_back(a);
                end
                if (mem_busy) begin
                    if (mem_left <= 1) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = word_of(mem_addr);
                        mem_busy       = 1'b0;
                    end else begin
                        mem_left--;
                    end
                end
            end
            imem_req_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            lat = rnd_lat ? int'($urandom_range(1, 3)) : fix_lat;
        end
    end

    // ---------------- reference model + monitor
    // Delivered stream after reset/redirect is simply pc0, pc0+4, ... with the
    // memory word of each address; nothing else may reach decode.
    logic [31:0] exp_pc;
    logic [31:0] pop_q[$];
    logic        ill_q[$];

    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [31:0] w;
        exp_pc = 32'h0;
        prev_stall = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_pc = 32'h0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && imem_req_valid)
                    chk("addr_hold", imem_req_addr, prev_addr);
                prev_stall = imem_req_valid && !imem_req_ready;
                prev_addr  = imem_req_addr;
                if (redirect_valid) begin
                    chk("rdr_no_valid", {31'b0, instr_valid}, 32'd0);
                    exp_pc = redirect_pc & ~32'd3;
                end else if (instr_valid) begin
                    w = word_of(exp_pc);
                    chk("head_pc", instr_pc, exp_pc);
                    chk("head_data", instr_data, w);
                    chk("head_op", {25'b0, instr_op}, {25'b0, w[6:0]});
                    chk("head_illegal", {31'b0, instr_illegal}, {31'b0, exp_illegal(w)});
                    if (instr_ready) begin
                        pop_q.push_back(instr_pc);
                        ill_q.push_back(instr_illegal);
                        exp_pc = exp_pc + 32'd4;
                    end
                end else begin
                    chk("idle_illegal", {31'b0, instr_illegal}, 32'd0);
                end
            end
        end
    end

    // ---------------- wrap instance responder (always ready, 1-cycle)
    logic [31:0] w_acc_q[$];
    logic [31:0] w_first_pc;
    logic        w_first_seen;

    initial begin
        logic wacc;
        w_req_ready = 1'b1;
        w_rsp_valid = 1'b0;
        w_rsp_data  = 32'h0000_0013;
        w_redirect_valid = 1'b0;
        w_redirect_pc = '0;
        w_instr_ready = 1'b1;
        w_first_seen = 1'b0;
        w_first_pc = '0;
        forever begin
            @(negedge clk);
            wacc = w_req_valid && w_req_ready;
            if (wacc && w_acc_q.size() < 3) w_acc_q.push_back(w_req_addr);
            if (w_instr_valid && !w_first_seen) begin
                w_first_pc   = w_instr_pc;
                w_first_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            w_rsp_valid = wacc && !reset;
        end
    end

    // ---------------- helpers
    task automatic wait_pops(input string tag, input int n);
        int i;
        for (i = 0; i < 300 && pop_q.size() < n; i++) @(posedge clk);
        chk(tag, {31'b0, pop_q.size() >= n}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_accs(input string tag, input int n);
        int i;
        for (i = 0; i < 300 && acc_q.size() < n; i++) @(posedge clk);
        chk(tag, {31'b0, acc_q.size() >= n}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence
    initial begin
        logic found;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        rnd_ready = 1'b0;
        rnd_lat = 1'b0;
        fix_lat = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_illegal", {31'b0, instr_illegal}, 32'd0);
        chk("rst_w_addr", w_req_addr, 32'hFFFF_FFF8);
        chk("rst_w_valid", {31'b0, w_req_valid}, 32'd0);

        // Decode stalled: two words buffered, fetch stops, nothing lost.
        @(posedge clk); #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("t2_full_valid", {31'b0, instr_valid}, 32'd1);
        chk("t2_req_stalled", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_two_reqs", acc_q.size(), 32'd2);
        @(posedge clk); #1 instr_ready = 1'b1;
        wait_pops("t2_pop_timeout", 3);
        if (pop_q.size() >= 3) begin
            chk("t2_pop0", pop_q[0], 32'h0);
            chk("t2_pop1", pop_q[1], 32'h4);
            chk("t2_pop2", pop_q[2], 32'h8);
        end
        if (acc_q.size() >= 3) begin
            chk("t1_addr0", acc_q[0], 32'h0);
            chk("t1_addr1", acc_q[1], 32'h4);
            chk("t1_addr2", acc_q[2], 32'h8);
        end

        // Redirect while a fetch is outstanding.
        fix_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #2;
            if (mem_busy && !imem_rsp_valid) found = 1'b1;
        end
        chk("t3_found_wait", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        acc_q.delete();
        pop_q.delete();
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_fifo_empty", {31'b0, instr_valid}, 32'd0);
        wait_pops("t3_pop_timeout", 1);
        if (acc_q.size() >= 1) chk("t3_req_addr", acc_q[0], 32'h0000_0100);
        if (pop_q.size() >= 1) chk("t3_first_pc", pop_q[0], 32'h0000_0100);

        // Redirect coincident with a response and a pop attempt.
        fix_lat = 2;
        instr_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #2;
            if (imem_rsp_valid && instr_valid) found = 1'b1;
        end
        chk("t4_found", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        chk("t4_fifo_empty", {31'b0, instr_valid}, 32'd0);
        chk("t4_reissue", {31'b0, imem_req_valid}, 32'd1);
        chk("t4_reissue_addr", imem_req_addr, 32'h0000_0300);
        @(posedge clk); #1 instr_ready = 1'b1;

        // Randomized traffic with redirects, including near the top of memory.
        rnd_ready = 1'b1;
        rnd_lat = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            if (redirect_valid) begin
                redirect_valid = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                         : ($urandom & 32'h0000_FFFF);
            end
        end

        // Opcode legality on known words.
        @(posedge clk); #1;
        rnd_ready = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        pop_q.delete();
        ill_q.delete();
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_pops("t6_pop_timeout", 2);
        if (pop_q.size() >= 2) begin
            chk("t6_pc0", pop_q[0], 32'h0000_0200);
            chk("t6_pc1", pop_q[1], 32'h0000_0204);
            chk("t6_lui_illegal", {31'b0, ill_q[0]}, {31'b0, exp_illegal(32'h0000_0037)});
            chk("t6_addi_illegal", {31'b0, ill_q[1]}, 32'd0);
        end

        // Reset in the middle of traffic.
        rnd_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("mid_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_addr", imem_req_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        acc_q.delete();
        pop_q.delete();
        reset = 1'b0;
        wait_pops("mid_rst_pop_timeout", 1);
        if (acc_q.size() >= 1) chk("mid_rst_first_addr", acc_q[0], 32'h0);
        if (pop_q.size() >= 1) chk("mid_rst_first_pc", pop_q[0], 32'h0);

        // Wrap instance.
        chk("t5_three_reqs", {31'b0, w_acc_q.size() >= 3}, 32'd1);
        if (w_acc_q.size() >= 3) begin
            chk("t5_addr0", w_acc_q[0], 32'hFFFF_FFF8);
            chk("t5_addr1", w_acc_q[1], 32'hFFFF_FFFC);
            chk("t5_addr2", w_acc_q[2], 32'h0000_0000);
        end
        chk("t5_first_pc", w_first_pc, 32'hFFFF_FFF8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
